// File: rtl/imem_byte_loader_if.sv
// Byte-stream input and instruction-memory write port
// of the boot-time program loader.
interface imem_byte_loader_if #(
  parameter int ADDR_W = 8
);
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    output byte_valid,
    output byte_data,
    input  byte_ready,
    input  imem_we,
    input  imem_addr,
    input  imem_wdata
  );

  modport slave (
    input  byte_valid,
    input  byte_data,
    output byte_ready,
    output imem_we,
    output imem_addr,
    output imem_wdata
  );
endinterface

// File: rtl/imem_byte_loader.sv
// Boot loader: MSB-first byte stream -> 32-bit imem words,
// holds the core in reset until the image is written.
module imem_byte_loader #(
  parameter int ADDR_W        = 8,
  parameter int RELEASE_DELAY = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [ADDR_W:0]     load_words,
  imem_byte_loader_if.slave   bus,
  output logic                core_reset_n,
  output logic                busy,
  output logic                done
);

  localparam logic [ADDR_W:0] DEPTH =
    {1'b1, {ADDR_W{1'b0}}};
  localparam int CW =
    (RELEASE_DELAY > 1) ? $clog2(RELEASE_DELAY) : 1;
  localparam logic [CW-1:0] REL_LAST =
    CW'(RELEASE_DELAY - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RELEASE,
    RUN
  } state_t;

  state_t          state;
  logic [ADDR_W:0] words;
  logic [ADDR_W:0] word_idx;
  logic [1:0]      byte_idx;
  logic [23:0]     shift;
  logic [CW-1:0]   rel_cnt;
  logic [ADDR_W:0] words_clamp;
  logic            accept;

  // Requested count limited to the memory depth
  always_comb begin
    words_clamp = load_words;
    if (load_words > DEPTH)
      words_clamp = DEPTH;
  end

  assign bus.byte_ready = (state == LOAD);
  assign accept = bus.byte_valid && bus.byte_ready;
  assign busy = (state == LOAD) || (state == RELEASE);

  // Load sequencer: assemble words, write, then release core
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      words          <= '0;
      word_idx       <= '0;
      byte_idx       <= '0;
      shift          <= '0;
      rel_cnt        <= '0;
      bus.imem_we    <= 1'b0;
      bus.imem_addr  <= '0;
      bus.imem_wdata <= '0;
      core_reset_n   <= 1'b0;
      done           <= 1'b0;
    end else begin
      bus.imem_we <= 1'b0;
      unique case (state)
        IDLE, RUN: begin
          if (start) begin
            words        <= words_clamp;
            word_idx     <= '0;
            byte_idx     <= '0;
            shift        <= '0;
            rel_cnt      <= '0;
            core_reset_n <= 1'b0;
            done         <= 1'b0;
            if (words_clamp == '0)
              state <= RELEASE;
            else
              state <= LOAD;
          end
        end
        LOAD: begin
          if (accept) begin
            if (byte_idx == 2'd3) begin
              bus.imem_we    <= 1'b1;
              bus.imem_addr  <= word_idx[ADDR_W-1:0];
              bus.imem_wdata <= {shift, bus.byte_data};
              word_idx       <= word_idx + 1'b1;
              byte_idx       <= '0;
              if (word_idx == words - 1'b1)
                state <= RELEASE;
            end else begin
              shift    <= {shift[15:0], bus.byte_data};
              byte_idx <= byte_idx + 1'b1;
            end
          end
        end
        RELEASE: begin
          if (rel_cnt == REL_LAST) begin
            core_reset_n <= 1'b1;
            done         <= 1'b1;
            state        <= RUN;
          end else begin
            rel_cnt <= rel_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/imem_byte_loader.md
# imem_byte_loader

Boot-time program loader sitting directly upstream of the fetch unit's instruction memory. It accepts a byte stream (most-significant byte of each instruction first), assembles 32-bit instruction words, and writes them into consecutive instruction-memory locations starting at address 0. It holds the CPU core in reset while loading and releases it a fixed number of cycles after the last word is written. This replaces simulation-only memory preloading with a synthesizable load path.

## Interface

Parameters:
- `ADDR_W`, 8: instruction-memory address width; `IMEM_DEPTH` = 2**ADDR_W words.
- `RELEASE_DELAY`, 2: cycles spent in RELEASE before core reset is deasserted; must be ≥1.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request to begin a load; honoured only in IDLE or RUN.
- `load_words`  in  ADDR_W+1  number of words to load, sampled on the accepted `start`; values above IMEM_DEPTH are clamped to IMEM_DEPTH.
- `byte_valid`  in  1  `byte_data` is valid.
- `byte_data`  in  8  stream byte.
- `byte_ready`  out  1  loader accepts a byte this cycle.
- `imem_we`  out  1  instruction-memory write strobe, one cycle per word.
- `imem_addr`  out  ADDR_W  word address for the write.
- `imem_wdata`  out  32  assembled instruction word.
- `core_reset_n`  out  1  active-low reset to the CPU core.
- `busy`  out  1  high in LOAD or RELEASE.
- `done`  out  1  high in RUN.

## Operation

- States: IDLE, LOAD, RELEASE, RUN. The reset state is IDLE.
- Reset values: `byte_ready`=0, `imem_we`=0, `imem_addr`=0, `imem_wdata`=0, `core_reset_n`=0, `busy`=0, `done`=0. Byte index, word index, and the partial word all clear.
- IDLE or RUN with `start`=1:
  - Latch the clamped `load_words`.
  - Drive `core_reset_n` low (registered), drop `done`, and clear the word and byte indices.
  - Go to LOAD if the count is nonzero; otherwise go to RELEASE.
- LOAD:
  - `byte_ready` = (state==LOAD), decoded from the state register.
  - A byte is accepted when `byte_valid` && `byte_ready`.
  - Each accepted byte shifts in: shift register ← {shift[23:0], byte_data}. The byte index counts 0..3.
  - On the 4th accepted byte, register `imem_we`=1, `imem_addr`=word index, and `imem_wdata`={shift[23:0], byte_data}. Then increment the word index and reset the byte index to 0.
  - When the accepted byte completes word (count−1), go to RELEASE on the same edge.
  - `byte_valid` low stalls indefinitely. There is no timeout.
- RELEASE:
  - Count RELEASE_DELAY cycles.
  - On the edge ending the last RELEASE cycle: `core_reset_n`←1, `done`←1, state←RUN.
- RUN: hold. `start` starts a reload, which reasserts core reset.
- `start` in LOAD or RELEASE is ignored. `load_words` is ignored except on an accepted `start`.
- Word index width is ADDR_W+1, so a count of IMEM_DEPTH terminates at address IMEM_DEPTH−1 with no wrap-around and no extra write to address 0.
- Asynchronous reset mid-load:
  - All outputs return to reset values and any partial word is discarded.
  - Words already written stay in memory; the loader does not clear them.

## Timing

- `start` accepted at edge s: state is LOAD (or RELEASE if the count is 0) from s; `core_reset_n`=0 from s.
- `byte_ready` rises in the cycle after edge s.
- 4th byte of word w accepted at edge e: `imem_we`=1 for exactly the cycle after e, with `imem_addr`=w. Latency is 1 cycle.
- `imem_we` is never high in two consecutive cycles. At most one write occurs per 4 byte handshakes.
- Last byte accepted at edge e:
  - `byte_ready`=0 from the cycle after e, even if `byte_valid` stays high.
  - `core_reset_n` and `done` rise at edge e+RELEASE_DELAY. `busy` falls on that same edge.
- Count 0 with `start` at edge s: `core_reset_n` rises at edge s+RELEASE_DELAY, with no `imem_we`.
- Best-case throughput: 1 byte/cycle, i.e. 4 cycles per word.

## Test plan

- Load 2 words, bytes 00 11 22 33 44 55 66 77 back-to-back, RELEASE_DELAY=2:
  - writes addr0=0x00112233 and addr1=0x44556677, each one cycle after its 4th byte;
  - `core_reset_n` and `done` rise 2 edges after the last byte.
- Same stream with `byte_valid` toggling every other cycle: identical writes and data, with no spurious `imem_we` during bubbles.
- `load_words`=0: no `imem_we`, `byte_ready` never high, `core_reset_n` rises at s+2.
- `load_words`=300 (clamped to 256), 1024 bytes of incrementing pattern:
  - last write is addr 255 = {FC,FD,FE,FF};
  - `byte_ready`=0 afterwards with `byte_valid` held high, and no write to addr 0 after the first.
- `reset_n` pulsed low after 6 bytes of a 2-word load:
  - all outputs go to reset values immediately;
  - a restart writes addr0 first with fresh data, with no leftover partial bytes.
- Reload from RUN: `start` at edge s drops `core_reset_n` and `done` from s; the new 1-word load overwrites addr0; `core_reset_n` rises again after RELEASE_DELAY.
